// File: rtl/btpipe_stream_buffer_if.sv
// Block-throttled pipe endpoint bundle between the capture buffer and an
// okBTPipeOut endpoint.
//   ep_read        : pop request from the endpoint
//   ep_blockstrobe : a block transfer is about to start
//   ep_datain      : registered word presented to the endpoint
//   ep_ready       : at least one full block is buffered
// master = endpoint side (drives read/strobe), slave = buffer side.
interface btpipe_stream_buffer_if;
  logic        ep_read;
  logic        ep_blockstrobe;
  logic [15:0] ep_datain;
  logic        ep_ready;

  modport master (
    output ep_read,
    output ep_blockstrobe,
    input  ep_datain,
    input  ep_ready
  );

  modport slave (
    input  ep_read,
    input  ep_blockstrobe,
    output ep_datain,
    output ep_ready
  );
endinterface

// File: rtl/btpipe_stream_buffer.sv
// Multi-channel capture buffer feeding an okBTPipeOut endpoint on ti_clk.
// Round-robin merges NCH sample streams, tags each word with its channel id
// (or writes a free-running test pattern) and stores words in a FIFO.
//   ti_clk, rst_n : clock, async active-low reset
//   ctrl_wire     : [0] enable, [1] pattern mode, [2] flush (sync clear)
//   ch_valid/data : per-channel samples, ch i at [i*DW +: DW]
//   ch_ack        : one-hot, channel sample consumed this cycle
//   ep            : pipe endpoint bundle (slave side)
//   fifo_count    : words stored
//   status_wire   : [0] overflow, [1] underrun, [2] full, [3] empty, [15:4] drops
module btpipe_stream_buffer #(
  parameter int NCH         = 4,
  parameter int CH_BITS     = 2,
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                          ti_clk,
  input  logic                          rst_n,
  input  logic [15:0]                   ctrl_wire,
  input  logic [NCH-1:0]                ch_valid,
  input  logic [NCH*(16-CH_BITS)-1:0]   ch_data,
  output logic [NCH-1:0]                ch_ack,
  btpipe_stream_buffer_if.slave         ep,
  output logic [DEPTH_LOG2:0]           fifo_count,
  output logic [15:0]                   status_wire
);

  localparam int DW  = 16 - CH_BITS;
  localparam int AW  = DEPTH_LOG2;
  localparam int BCW = $clog2(BLOCK_WORDS + 1);

  typedef enum logic {BLK_IDLE, BLK_ACTIVE} blk_state_t;

  logic enable, pat_mode, flush, ctrl_unused;
  assign enable      = ctrl_wire[0];
  assign pat_mode    = ctrl_wire[1];
  assign flush       = ctrl_wire[2];
  assign ctrl_unused = ^ctrl_wire[15:3];

  logic [15:0]        mem [2**AW];
  logic [AW:0]        wr_ptr, rd_ptr;
  logic [15:0]        pat_cnt;
  logic [CH_BITS-1:0] rr_ptr;
  logic               overflow, underrun;
  logic [11:0]        drop_cnt;
  logic [BCW-1:0]     blk_cnt;
  blk_state_t         state, state_next;

  logic               full, empty;
  logic [DW-1:0]      samples [NCH];
  logic               grant_found;
  logic [CH_BITS-1:0] grant_id, idx;
  logic               wr_req, wr_do, rd_req, rd_do, drop, ready_force;
  logic [15:0]        wr_word;

  assign fifo_count  = wr_ptr - rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign status_wire = {drop_cnt, empty, full, underrun, overflow};

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) samples[i] = ch_data[i*DW +: DW];
  end

  // First valid channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      idx = CH_BITS'((32'(rr_ptr) + off) % NCH);
      if (!grant_found && ch_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    wr_req  = 1'b0;
    wr_word = '0;
    ch_ack  = '0;
    if (!flush && enable) begin
      if (pat_mode) begin
        wr_req  = 1'b1;
        wr_word = pat_cnt;
      end else if (grant_found) begin
        wr_req  = 1'b1;
        wr_word = {grant_id, samples[grant_id]};
        ch_ack  = NCH'(1) << grant_id;
      end
    end
  end

  // A write into a full FIFO still lands when a pop happens on the same edge.
  assign rd_req = ep.ep_read && !flush;
  assign rd_do  = rd_req && !empty;
  assign wr_do  = wr_req && (!full || rd_do);
  assign drop   = wr_req && !wr_do;

  // Block tracking: ep_ready is held low from the strobe edge until
  // BLOCK_WORDS reads have been seen; a new strobe restarts the count.
  always_comb begin
    state_next  = state;
    ready_force = (state == BLK_ACTIVE) || ep.ep_blockstrobe;
    case (state)
      BLK_IDLE:
        if (ep.ep_blockstrobe) state_next = BLK_ACTIVE;
      BLK_ACTIVE:
        if (!ep.ep_blockstrobe && ep.ep_read && blk_cnt == BCW'(BLOCK_WORDS - 1))
          state_next = BLK_IDLE;
      default: state_next = BLK_IDLE;
    endcase
    if (flush) state_next = BLK_IDLE;
  end

  always_ff @(posedge ti_clk) begin
    if (wr_do) mem[wr_ptr[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ep.ep_datain <= '0;
      ep.ep_ready  <= 1'b0;
      overflow     <= 1'b0;
      underrun     <= 1'b0;
      drop_cnt     <= '0;
      pat_cnt      <= '0;
      rr_ptr       <= '0;
      blk_cnt      <= '0;
      state        <= BLK_IDLE;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ep.ep_datain <= '0;
      ep.ep_ready  <= 1'b0;
      overflow     <= 1'b0;
      underrun     <= 1'b0;
      drop_cnt     <= '0;
      pat_cnt      <= '0;
      rr_ptr       <= '0;
      blk_cnt      <= '0;
      state        <= BLK_IDLE;
    end else begin
      state <= state_next;
      if (wr_do) wr_ptr <= wr_ptr + 1'b1;
      if (rd_do) begin
        rd_ptr       <= rd_ptr + 1'b1;
        ep.ep_datain <= mem[rd_ptr[AW-1:0]];
      end else if (rd_req) begin
        ep.ep_datain <= '0;
        underrun     <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
      if (enable && pat_mode) pat_cnt <= pat_cnt + 1'b1;
      if (enable && !pat_mode && grant_found)
        rr_ptr <= (grant_id == CH_BITS'(NCH - 1)) ? '0 : grant_id + 1'b1;
      if (ep.ep_blockstrobe) blk_cnt <= '0;
      else if (state == BLK_ACTIVE && ep.ep_read) blk_cnt <= blk_cnt + 1'b1;
      ep.ep_ready <= !ready_force && (fifo_count >= (AW+1)'(BLOCK_WORDS));
    end
  end

endmodule
